// File: rtl/lsu_if.sv
// lsu_if: request/response and data-memory signals of the load/store unit
interface lsu_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [63:0] load_data;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output busy, done, fault, load_data, mem_addr, mem_wdata, mem_wr
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  busy, done, fault, load_data, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RISC-V load/store FSM on a doubleword memory.
// Define LSU_ALIGN_CHECK_EN to fault misaligned h/w/d accesses instead of forcing alignment.
module load_store_unit #(
  parameter int READ_WAIT = 1
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
  state_t      state, state_n;
  logic [1:0]  cnt;
  logic [63:0] addr_r, wdata_r, load_data_r, mem_wdata_r;
  logic [2:0]  f3_r;
  logic        we_r, fault_r;
  logic [1:0]  size_i;
  logic        illegal, mis;
  logic [63:0] amask;
  logic [5:0]  sh;
  logic [63:0] s, ext, bmask, lane, merged;
  logic        sgn;
  assign size_i  = bus.req_funct3[1:0];
  assign illegal = (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
`ifdef LSU_ALIGN_CHECK_EN
  assign mis   = (size_i == 2'd1 && bus.req_addr[0]) ||
                 (size_i == 2'd2 && |bus.req_addr[1:0]) ||
                 (size_i == 2'd3 && |bus.req_addr[2:0]);
  assign amask = '1;
`else
  assign mis   = 1'b0;
  assign amask = size_i == 2'd3 ? ~64'h7 : size_i == 2'd2 ? ~64'h3 :
                 size_i == 2'd1 ? ~64'h1 : '1;
`endif
  assign sh     = {addr_r[2:0], 3'b000};
  assign s      = bus.mem_rdata >> sh;
  assign sgn    = ~f3_r[2];
  assign ext    = f3_r[1:0] == 2'd0 ? {{56{sgn & s[7]}}, s[7:0]} :
                  f3_r[1:0] == 2'd1 ? {{48{sgn & s[15]}}, s[15:0]} :
                  f3_r[1:0] == 2'd2 ? {{32{sgn & s[31]}}, s[31:0]} : s;
  assign bmask  = f3_r[1:0] == 2'd0 ? 64'hFF : f3_r[1:0] == 2'd1 ? 64'hFFFF :
                  f3_r[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
  assign lane   = bmask << sh;
  assign merged = (bus.mem_rdata & ~lane) | ((wdata_r & bmask) << sh);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.req_valid)
              state_n = (illegal || mis) ? DONE : (bus.req_we && size_i == 2'd3) ? WR : RD;
      RD:   state_n = cnt == 2'(READ_WAIT - 1) ? CAP : RD;
      CAP:  state_n = we_r ? WR : DONE;
      WR:   state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      f3_r        <= '0;
      we_r        <= 1'b0;
      fault_r     <= 1'b0;
      load_data_r <= '0;
      mem_wdata_r <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == RD ? cnt + 2'd1 : 2'd0;
      if (state == IDLE && bus.req_valid) begin
        addr_r  <= bus.req_addr & amask;
        f3_r    <= bus.req_funct3;
        we_r    <= bus.req_we;
        wdata_r <= bus.req_wdata;
        fault_r <= illegal || mis;
        if (illegal || mis) load_data_r <= '0;
        if (bus.req_we && size_i == 2'd3) mem_wdata_r <= bus.req_wdata;
      end
      if (state == CAP) begin
        if (we_r) mem_wdata_r <= merged;
        else load_data_r <= ext;
      end
    end
  end
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.mem_wr    = state == WR;
  assign bus.fault     = fault_r;
  assign bus.load_data = load_data_r;
  assign bus.mem_addr  = {addr_r[63:3], 3'b000};
  assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter READ_WAIT, default 1: cycles mem_addr is held before mem_rdata is sampled, legal range 1..4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  request strobe; sampled only in IDLE.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_funct3  input  3  RISC-V size/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-007 req_addr  input  64  byte address from the ALUOut register.
REQ-008 req_wdata  input  64  store data from RegB; low bytes used.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 fault  output  1  valid with done; request was illegal or misaligned.
REQ-012 load_data  output  64  extended load result; held until the next done.
REQ-013 mem_addr  output  64  doubleword address {addr[63:3],3'b000} to the data memory.
REQ-014 mem_wdata  output  64  full doubleword write data.
REQ-015 mem_wr  output  1  data memory write enable.
REQ-016 mem_rdata  input  64  data memory read doubleword.

Function
REQ-017 The FSM SHALL have states IDLE, RD, CAP, WR and DONE.
REQ-018 IDLE with req_valid=1 SHALL latch addr, funct3, we and wdata; the latched values SHALL drive all later states.
REQ-019 Loads SHALL go IDLE->RD (READ_WAIT cycles)->CAP->DONE; CAP samples mem_rdata and registers load_data.
REQ-020 sd SHALL go IDLE->WR->DONE with no read.
REQ-021 sb/sh/sw SHALL go IDLE->RD->CAP->WR->DONE; CAP merges the store bytes into the sampled doubleword.
REQ-022 Byte lane SHALL be addr[2:0], little-endian: byte k occupies bits [8k+7:8k].
REQ-023 b/h/w loads SHALL sign-extend to 64 bits; bu/hu/wu loads SHALL zero-extend.
REQ-024 mem_wr SHALL be high for exactly the single WR cycle; mem_wdata SHALL equal the merged doubleword (sd: req_wdata).
REQ-025 With READ_WAIT=1, done SHALL be high in the 3rd cycle after the accept edge for loads, the 4th for partial stores and the 2nd for sd.
REQ-026 req_valid in any state other than IDLE SHALL be ignored, not queued.
REQ-027 DONE SHALL always return to IDLE on the next edge; busy stays 1 in DONE.
REQ-028 funct3=111, or a store with funct3>=100, SHALL be illegal: IDLE->DONE, fault=1, load_data=0, no mem_wr.
REQ-029 mem_addr SHALL be driven continuously from the latched address; it is don't-care in IDLE.

Reset
REQ-030 rst=1 SHALL force IDLE on the next edge from any state, including mid-RD/CAP/WR, and discard the transaction.
REQ-031 Reset values SHALL be: busy=0, done=0, fault=0, load_data=0, mem_wr=0, mem_wdata=0, mem_addr=0.
REQ-032 No mem_wr pulse SHALL occur for a transaction interrupted by reset.

Configuration
REQ-033 With macro LSU_ALIGN_CHECK_EN defined, h/w/d accesses with addr[0], addr[1:0] or addr[2:0] nonzero respectively SHALL take IDLE->DONE with fault=1, load_data=0 and no mem_wr.
REQ-034 Without LSU_ALIGN_CHECK_EN, the offset bits below the access size SHALL be cleared (natural alignment forced), no alignment fault SHALL be raised, and illegal funct3 faults SHALL remain.

Verification
REQ-035 Memory[0x100]=0x8877665544332211; lb at 0x107 -> load_data=0xFFFFFFFFFFFFFF88, fault=0; lbu at 0x107 -> 0x0000000000000088.
REQ-036 Memory[0x100]=0x1111111111111111; sb wdata=0xAB at 0x102 -> single mem_wr cycle, mem_wdata=0x1111111111AB1111, done in cycle 4.
REQ-037 sd 0xDEADBEEF00000000 at 0x200 -> mem_wr in cycle 1 after accept, mem_wdata=0xDEADBEEF00000000, done in cycle 2, no CAP state.
REQ-038 lw at 0x102: with LSU_ALIGN_CHECK_EN -> fault=1, load_data=0, no mem_wr; without -> data from bytes 0x100..0x103, fault=0.
REQ-039 sh at 0x104 with rst asserted while in CAP -> mem_wr never asserts, busy=0 after the next edge, memory unchanged.
REQ-040 Second req_valid pulse while busy -> ignored: exactly one done and one memory access result.
